// File: rtl/arbitro_vc_d.sv
// Virtual-channel arbiter: pops VC0/VC1 FIFOs with strict VC0 priority and
// forwards each word to D0/D1 by bit 4, two cycles after its pop.
module arbitro_vc_d (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       init,
    input  logic [1:0] umbral_D0_in,
    input  logic [1:0] umbral_D1_in,
    input  logic [3:0] umbral_VC0_in,
    input  logic [3:0] umbral_VC1_in,
    output logic [1:0] umbral_D0_out,
    output logic [1:0] umbral_D1_out,
    output logic [3:0] umbral_VC0_out,
    output logic [3:0] umbral_VC1_out,
    input  logic       vc0_empty,
    input  logic       vc1_empty,
    input  logic [5:0] vc0_data,
    input  logic [5:0] vc1_data,
    input  logic       d0_almost_full,
    input  logic       d1_almost_full,
    input  logic       fifo_error,
    output logic       pop_vc0,
    output logic       pop_vc1,
    output logic       push_d0,
    output logic       push_d1,
    output logic [5:0] data_out,
    output logic       active_out,
    output logic       idle_out,
    output logic       error_out
);
    typedef enum logic [2:0] {RESET, INIT, IDLE, ACTIVE, ERROR} state_t;

    state_t     state_q, state_d;
    logic [1:0] pop_q;            // stage 0 of the in-flight pipeline: {vc1, vc0}
    logic       vld1_q, src1_q;   // stage 1: read data is on the VC bus this cycle
    logic       push_d0_q, push_d1_q;
    logic [5:0] data_q;
    logic       active_q, idle_q, error_q;
    logic [1:0] ud0_q, ud1_q;
    logic [3:0] uvc0_q, uvc1_q;

    logic       can_pop, pop0_d, pop1_d, flush, push_en;
    logic [5:0] word;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET:   state_d = INIT;
            INIT:    if (!init) state_d = IDLE;
            IDLE:    if (init) state_d = INIT;
                     else if (!vc0_empty || !vc1_empty) state_d = ACTIVE;
            ACTIVE:  if (init) state_d = INIT;
                     else if (vc0_empty && vc1_empty && pop_q == 2'b00 && !vld1_q)
                         state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = RESET;
        endcase
        if (state_q != RESET && fifo_error) state_d = ERROR;
    end

    // The empty flag lags a pop by a cycle, so a VC is never popped back to back.
    assign can_pop = (state_q == ACTIVE) && (state_d == ACTIVE) &&
                     !d0_almost_full && !d1_almost_full;
    assign pop0_d  = can_pop && !vc0_empty && !pop_q[0];
    assign pop1_d  = can_pop && !vc1_empty && !pop_q[1] && !pop0_d;

    assign flush   = (state_d == ERROR);
    assign push_en = vld1_q && !flush;
    assign word    = src1_q ? vc1_data : vc0_data;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= RESET;
            pop_q     <= 2'b00;
            vld1_q    <= 1'b0;
            src1_q    <= 1'b0;
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            data_q    <= 6'b0;
            active_q  <= 1'b0;
            idle_q    <= 1'b0;
            error_q   <= 1'b0;
            ud0_q     <= 2'd0;
            ud1_q     <= 2'd0;
            uvc0_q    <= 4'd0;
            uvc1_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            pop_q     <= {pop1_d, pop0_d};
            vld1_q    <= (|pop_q) && !flush;
            src1_q    <= pop_q[1];
            push_d0_q <= push_en && !word[4];
            push_d1_q <= push_en && word[4];
            if (push_en) data_q <= word;
            active_q  <= (state_d == ACTIVE);
            idle_q    <= (state_d == IDLE);
            error_q   <= (state_d == ERROR);
            if (state_q == INIT) begin
                ud0_q  <= umbral_D0_in;
                ud1_q  <= umbral_D1_in;
                uvc0_q <= umbral_VC0_in;
                uvc1_q <= umbral_VC1_in;
            end
        end
    end

    assign pop_vc0        = pop_q[0];
    assign pop_vc1        = pop_q[1];
    assign push_d0        = push_d0_q;
    assign push_d1        = push_d1_q;
    assign data_out       = data_q;
    assign active_out     = active_q;
    assign idle_out       = idle_q;
    assign error_out      = error_q;
    assign umbral_D0_out  = ud0_q;
    assign umbral_D1_out  = ud1_q;
    assign umbral_VC0_out = uvc0_q;
    assign umbral_VC1_out = uvc1_q;
endmodule

// File: tb/tb_arbitro_vc_d.sv
// Bench for arbitro_vc_d: directed vector table plus randomized traffic
// checked against a transaction-level reference model.
module tb_arbitro_vc_d;
    logic       clk = 1'b0, reset_L = 1'b1, init = 1'b0;
    logic [1:0] uD0_in = 2'd2, uD1_in = 2'd1;
    logic [3:0] uVC0_in = 4'd5, uVC1_in = 4'd9;
    logic [1:0] uD0_out, uD1_out;
    logic [3:0] uVC0_out, uVC1_out;
    logic       vc0_empty = 1'b1, vc1_empty = 1'b1;
    logic [5:0] vc0_data = 6'd0, vc1_data = 6'd0;
    logic       d0_af = 1'b0, d1_af = 1'b0, fifo_error = 1'b0;
    logic       pop_vc0, pop_vc1, push_d0, push_d1;
    logic [5:0] data_out;
    logic       active_out, idle_out, error_out;

    int checks = 0, errors = 0;

    arbitro_vc_d dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_D0_in(uD0_in), .umbral_D1_in(uD1_in),
        .umbral_VC0_in(uVC0_in), .umbral_VC1_in(uVC1_in),
        .umbral_D0_out(uD0_out), .umbral_D1_out(uD1_out),
        .umbral_VC0_out(uVC0_out), .umbral_VC1_out(uVC1_out),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_af), .d1_almost_full(d1_af), .fifo_error(fifo_error),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .active_out(active_out), .idle_out(idle_out),
        .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // VC FIFO environment: data appears the cycle after the FIFO samples pop.
    logic       add0 = 1'b0, add1 = 1'b0;
    logic [5:0] w0 = 6'd0, w1 = 6'd0;
    logic [5:0] q0[$], q1[$], mq0[$], mq1[$];
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q0.delete(); q1.delete(); mq0.delete(); mq1.delete();
            vc0_empty <= 1'b1; vc1_empty <= 1'b1;
        end else begin
            if (pop_vc0 && q0.size() > 0) vc0_data <= q0.pop_front();
            if (pop_vc1 && q1.size() > 0) vc1_data <= q1.pop_front();
            if (add0) begin q0.push_back(w0); mq0.push_back(w0); end
            if (add1) begin q1.push_back(w1); mq1.push_back(w1); end
            vc0_empty <= (q0.size() == 0);
            vc1_empty <= (q1.size() == 0);
        end
    end

    // Reference model: mode per the specified rules, pending pushes as a
    // queue of {due cycle, word} taken from its own copy of the VC contents.
    localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;
    typedef struct { int due; logic [5:0] w; } pend_t;
    pend_t      pend[$];
    int         m_mode = M_RST, m_nm = M_RST, m_cyc = 0;
    logic       m_pop0 = 0, m_pop1 = 0, np0, np1, go;
    logic       e_pd0 = 0, e_pd1 = 0;
    logic [5:0] e_data = 0, mw;
    logic [1:0] e_ud0 = 0, e_ud1 = 0;
    logic [3:0] e_uvc0 = 0, e_uvc1 = 0;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_mode = M_RST; m_pop0 = 0; m_pop1 = 0; e_pd0 = 0; e_pd1 = 0;
            e_data = 0; e_ud0 = 0; e_ud1 = 0; e_uvc0 = 0; e_uvc1 = 0;
            pend.delete();
        end else begin
            m_cyc++;
            if (m_mode == M_RST)                      m_nm = M_INIT;
            else if (fifo_error || m_mode == M_ERR)   m_nm = M_ERR;
            else if (m_mode == M_INIT)                m_nm = init ? M_INIT : M_IDLE;
            else if (init)                            m_nm = M_INIT;
            else if (m_mode == M_IDLE)                m_nm = (!vc0_empty || !vc1_empty) ? M_ACT : M_IDLE;
            else m_nm = (vc0_empty && vc1_empty && !m_pop0 && !m_pop1 && pend.size() == 0) ? M_IDLE : M_ACT;
            if (m_mode == M_INIT) begin
                e_ud0 = uD0_in; e_ud1 = uD1_in; e_uvc0 = uVC0_in; e_uvc1 = uVC1_in;
            end
            go  = (m_mode == M_ACT) && (m_nm == M_ACT) && !d0_af && !d1_af;
            np0 = go && !vc0_empty && !m_pop0;
            np1 = go && !vc1_empty && !m_pop1 && !np0;
            e_pd0 = 0; e_pd1 = 0;
            if (m_nm == M_ERR) pend.delete();
            else if (pend.size() > 0 && pend[0].due == m_cyc) begin
                mw = pend[0].w; void'(pend.pop_front());
                e_data = mw; e_pd1 = mw[4]; e_pd0 = !mw[4];
            end
            if (np0) begin mw = (mq0.size() > 0) ? mq0.pop_front() : 6'd0; pend.push_back('{m_cyc + 2, mw}); end
            if (np1) begin mw = (mq1.size() > 0) ? mq1.pop_front() : 6'd0; pend.push_back('{m_cyc + 2, mw}); end
            m_pop0 = np0; m_pop1 = np1; m_mode = m_nm;
        end
    end

    always @(posedge clk) begin
        #3;
        chk($sformatf("model cyc%0d", m_cyc),
            {7'd0, pop_vc0, pop_vc1, push_d0, push_d1, data_out, active_out, idle_out,
             error_out, uD0_out, uD1_out, uVC0_out, uVC1_out},
            {7'd0, m_pop0, m_pop1, e_pd0, e_pd1, e_data, m_mode == M_ACT, m_mode == M_IDLE,
             m_mode == M_ERR, e_ud0, e_ud1, e_uvc0, e_uvc1});
    end

    typedef struct {
        logic rst, ini, af1, fe, a0; logic [5:0] w0; logic a1; logic [5:0] w1;
        logic p0, p1, d0, d1; logic [5:0] dat; logic [2:0] st;
    } row_t;
    localparam logic [2:0] A = 3'b100, I = 3'b010, E = 3'b001, Z = 3'b000;

    function automatic row_t R(input logic rst, ini, af1, fe, a0, input logic [5:0] w0v,
                               input logic a1, input logic [5:0] w1v, input logic p0, p1, d0, d1,
                               input logic [5:0] dat, input logic [2:0] st);
        row_t r;
        r.rst = rst; r.ini = ini; r.af1 = af1; r.fe = fe; r.a0 = a0; r.w0 = w0v;
        r.a1 = a1; r.w1 = w1v; r.p0 = p0; r.p1 = p1; r.d0 = d0; r.d1 = d1;
        r.dat = dat; r.st = st;
        return r;
    endfunction

    row_t tbl[$];

    initial begin
        // reset, init/thresholds, single-VC drain
        tbl.push_back(R(0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,1,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,1,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, I));
        tbl.push_back(R(1,0,0,0, 1,6'b011011,0,0, 0,0,0,0, 6'b000000, I));
        tbl.push_back(R(1,0,0,0, 1,6'b000011,0,0, 0,0,0,0, 6'b000000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,0,0, 6'b000000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,0,1, 6'b011011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b011011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,1,0, 6'b000011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000011, I));
        // both VCs: alternation VC0, VC1, VC0
        tbl.push_back(R(1,0,0,0, 1,6'b100001,1,6'b101101, 0,0,0,0, 6'b000011, I));
        tbl.push_back(R(1,0,0,0, 1,6'b010000,0,0, 0,0,0,0, 6'b000011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,0,0, 6'b000011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,1,0,0, 6'b000011, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,1,0, 6'b100001, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,1,0, 6'b101101, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,1, 6'b010000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b010000, I));
        // destination almost-full back-pressure
        tbl.push_back(R(1,0,1,0, 1,6'b000111,0,0, 0,0,0,0, 6'b010000, I));
        tbl.push_back(R(1,0,1,0, 0,0,0,0, 0,0,0,0, 6'b010000, A));
        tbl.push_back(R(1,0,1,0, 0,0,0,0, 0,0,0,0, 6'b010000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,0,0, 6'b010000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b010000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,1,0, 6'b000111, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000111, I));
        // sticky error
        tbl.push_back(R(1,0,0,0, 1,6'b110000,0,0, 0,0,0,0, 6'b000111, I));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000111, A));
        tbl.push_back(R(1,0,0,1, 0,0,0,0, 0,0,0,0, 6'b000111, E));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000111, E));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000111, E));
        // reset clears error, then reset right after a pop drops the word
        tbl.push_back(R(0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,1,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, I));
        tbl.push_back(R(1,0,0,0, 1,6'b011111,0,0, 0,0,0,0, 6'b000000, I));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, A));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 1,0,0,0, 6'b000000, A));
        tbl.push_back(R(0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, Z));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, I));
        tbl.push_back(R(1,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000, I));

        #1 reset_L = 1'b0;
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            reset_L = tbl[i].rst; init = tbl[i].ini; d1_af = tbl[i].af1;
            fifo_error = tbl[i].fe; add0 = tbl[i].a0; w0 = tbl[i].w0;
            add1 = tbl[i].a1; w1 = tbl[i].w1;
            if (!tbl[i].rst) begin
                #1;
                chk($sformatf("async reset row%0d", i),
                    {pop_vc0, pop_vc1, push_d0, push_d1, data_out, active_out, idle_out,
                     error_out, uD0_out, uD1_out, uVC0_out, uVC1_out}, 32'd0);
            end
            @(negedge clk);
            chk($sformatf("vector row%0d", i),
                {pop_vc0, pop_vc1, push_d0, push_d1, data_out, active_out, idle_out, error_out},
                {tbl[i].p0, tbl[i].p1, tbl[i].d0, tbl[i].d1, tbl[i].dat, tbl[i].st});
            if (i == 1)
                chk("thresholds still reset", {uD0_out, uD1_out, uVC0_out, uVC1_out}, 32'd0);
            if (i == 3)
                chk("thresholds latched", {uD0_out, uD1_out, uVC0_out, uVC1_out},
                    {2'd2, 2'd1, 4'd5, 4'd9});
        end

        // randomized traffic, back-pressure, init/error/reset events
        for (int c = 0; c < 1500; c++) begin
            reset_L    = ($urandom_range(0, 299) != 0);
            init       = ($urandom_range(0, 99) == 0);
            fifo_error = ($urandom_range(0, 399) == 0);
            d0_af      = ($urandom_range(0, 4) == 0);
            d1_af      = ($urandom_range(0, 4) == 0);
            add0       = (q0.size() < 6) && ($urandom_range(0, 2) == 0);
            add1       = (q1.size() < 6) && ($urandom_range(0, 2) == 0);
            w0 = 6'($urandom); w1 = 6'($urandom);
            uD0_in = 2'($urandom); uD1_in = 2'($urandom);
            uVC0_in = 4'($urandom); uVC1_in = 4'($urandom);
            @(negedge clk);
        end
        reset_L = 1'b1; init = 1'b0; fifo_error = 1'b0; add0 = 1'b0; add1 = 1'b0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbitro_vc_d.md
ARBITRO_VC_D -- requirements
Module: arbitro_vc_d

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset_L  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: init  in  1  configuration request; thresholds are latched while in INIT.
REQ-004 SHALL have: umbral_D0_in, umbral_D1_in  in  2 each  almost-full thresholds for D0/D1 FIFOs.
REQ-005 SHALL have: umbral_VC0_in, umbral_VC1_in  in  4 each  almost-full thresholds for VC0/VC1 FIFOs.
REQ-006 SHALL have: umbral_D0_out, umbral_D1_out (2 each), umbral_VC0_out, umbral_VC1_out (4 each)  out  registered thresholds driven to the FIFOs.
REQ-007 SHALL have: vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags.
REQ-008 SHALL have: vc0_data, vc1_data  in  6 each  VC FIFO read data, valid the cycle after the FIFO samples pop.
REQ-009 SHALL have: d0_almost_full, d1_almost_full  in  1 each  destination FIFO almost-full flags.
REQ-010 SHALL have: fifo_error  in  1  OR of all FIFO overflow/underflow flags.
REQ-011 SHALL have: pop_vc0, pop_vc1, push_d0, push_d1  out  1 each  registered FIFO strobes.
REQ-012 SHALL have: data_out  out  6  word written to D0/D1; bit4 = destination (0 -> D0, 1 -> D1).
REQ-013 SHALL have: active_out, idle_out, error_out  out  1 each  registered one-hot status.

Function
REQ-014 SHALL implement FSM states RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-015 SHALL transition RESET -> INIT on first rising edge with reset_L=1.
REQ-016 SHALL, in INIT, load all umbral_*_out from umbral_*_in every cycle; INIT -> IDLE on edge where init=0.
REQ-017 SHALL transition IDLE -> ACTIVE when vc0_empty=0 or vc1_empty=0.
REQ-018 SHALL transition ACTIVE -> IDLE when both VC FIFOs empty, no pop issued last cycle, no word in flight.
REQ-019 SHALL transition IDLE/ACTIVE -> INIT when init=1; no new pops in INIT; in-flight words still complete their push.
REQ-020 SHALL transition any non-RESET state -> ERROR when fifo_error=1; ERROR sticky until reset_L=0; no pop/push in ERROR.
REQ-021 SHALL drive idle_out=1 only in IDLE, active_out=1 only in ACTIVE, error_out=1 only in ERROR; all 0 in RESET/INIT; registered (Moore).
REQ-022 SHALL issue pops only in ACTIVE, and only when d0_almost_full=0 and d1_almost_full=0 (destination unknown before read).
REQ-023 SHALL arbitrate strict priority: VC0 over VC1; at most one pop per cycle.
REQ-024 SHALL NOT pop the same VC on two consecutive cycles (guards stale empty flag); the other VC is eligible in the gap cycle.
REQ-025 SHALL, two edges after registering pop_vcX=1, register data_out = vcX_data captured the cycle after pop, and push_d0 = ~data[4], push_d1 = data[4]; latency pop -> push = 2 cycles.
REQ-026 SHALL keep data_out at last pushed value when no push; push strobes are single-cycle per word.
REQ-027 SHALL track in-flight words with a 2-stage valid/source pipeline; depth never exceeds 2.

Reset
REQ-028 SHALL, on reset_L=0, asynchronously force state RESET, all strobes 0, data_out=6'b0, status outputs 0, umbral_D*_out=2'd0, umbral_VC*_out=4'd0, pipeline cleared.
REQ-029 SHALL discard in-flight words on reset mid-operation (no push after reset asserts).

Verification
REQ-030 Reset 1 cycle, init 1 cycle with umbral_D0_in=2, umbral_VC0_in=5 -> umbral_D0_out=2, umbral_VC0_out=5 after INIT; idle_out=1 next cycle.
REQ-031 VC0 holds 6'b011011 then 6'b000011, VC1 empty -> pop_vc0 on cycles t and t+2; push_d1 with data_out=6'b011011 at t+2, push_d0 with 6'b000011 at t+4; active_out then idle_out after drain.
REQ-032 Both VCs non-empty (VC1 word 6'b101101) -> pops alternate VC0, VC1, VC0; VC1 word pushed to D0 two cycles after its pop.
REQ-033 d1_almost_full=1 while VCs non-empty -> no pops; deassert -> pop resumes next registered cycle.
REQ-034 fifo_error=1 one cycle in ACTIVE -> error_out=1 next cycle, all strobes 0, stays until reset_L=0.
REQ-035 reset_L=0 one cycle after a pop -> no push follows; all outputs at reset values immediately.
